gshare_branch_predictor: RTL and testbench

Fetch-side dynamic branch predictor for the 5-bit-PC pipeline. It combines a 16-entry gshare pattern history table of 2-bit counters, a 4-bit global history register and a 16-entry direct-mapped branch target buffer. At fetch it returns `prediction`, `hit`, the predicted target and `GHR_value`; the decode stage registers these through to execute. From execute it consumes the registered resolution (`Pc_Xor_GR`, `real_Value`, `prediction`, `hit`, `Branch`/`bne`). It updates its tables and raises `flush_hit` with a redirect PC on a misprediction.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/btb_table.sv | 34 +++
 rtl/gshare_branch_predictor.sv | 83 ++++++++
 tb/tb_gshare_branch_predictor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared widths, counter encoding and BTB entry layout for the gshare branch predictor.
package bp_pkg;

  localparam int unsigned PC_W      = 5;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned TAG_W     = PC_W - IDX_W;
  localparam int unsigned TBL_DEPTH = 1 << IDX_W;
  localparam int unsigned STAT_W    = 16;

  typedef enum logic [CNT_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e PHT_RST = WNT;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: combinational read, synchronous write and reset.
module btb_table
  import bp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [PC_W-1:0]  rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target
);

  btb_entry_t mem [TBL_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(TBL_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target};
    end
  end

  // No write bypass: a same-cycle reader sees the pre-write entry.
  assign rd_valid  = mem[rd_idx].valid;
  assign rd_tag    = mem[rd_idx].tag;
  assign rd_target = mem[rd_idx].target;

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: PHT of 2-bit counters indexed by pc^GHR, non-speculative GHR,
// BTB for targets, and execute-stage misprediction detection with redirect.
module gshare_branch_predictor #(
  parameter int unsigned PC_W  = bp_pkg::PC_W,
  parameter int unsigned IDX_W = bp_pkg::IDX_W,
  parameter int unsigned CNT_W = bp_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc_F,
  output logic             prediction,
  output logic             hit,
  output logic [PC_W-1:0]  pred_target,
  output logic [IDX_W-1:0] GHR_value,
  input  logic             res_valid,
  input  logic [PC_W-1:0]  res_pc,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  input  logic             res_pred,
  input  logic             res_hit,
  input  logic [PC_W-1:0]  res_target,
  output logic             flush_hit,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [15:0]      br_count,
  output logic [15:0]      mp_count
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = PC_W - IDX_W;

  logic [CNT_W-1:0] pht [DEPTH];
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] fetch_idx;
  logic             btb_valid;
  logic [TAG_W-1:0] btb_tag;
  logic             mispredict;

  btb_table u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_F[IDX_W-1:0]),
    .rd_valid  (btb_valid),
    .rd_tag    (btb_tag),
    .rd_target (pred_target),
    .wr_en     (res_valid & res_taken),
    .wr_idx    (res_pc[IDX_W-1:0]),
    .wr_tag    (res_pc[PC_W-1:IDX_W]),
    .wr_target (res_target)
  );

  // Fetch-side read
  assign fetch_idx  = pc_F[IDX_W-1:0] ^ ghr;
  assign prediction = pht[fetch_idx][CNT_W-1];
  assign hit        = btb_valid & (btb_tag == pc_F[PC_W-1:IDX_W]);
  assign GHR_value  = ghr;

  // Execute-side resolution
  assign mispredict  = res_valid & ((res_hit & res_pred) != res_taken);
  assign flush_hit   = mispredict;
  assign redirect_pc = !mispredict ? '0 :
                       res_taken   ? res_target : res_pc + PC_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pht[i] <= CNT_W'(bp_pkg::PHT_RST);
      end
      ghr      <= '0;
      br_count <= '0;
      mp_count <= '0;
    end else if (res_valid) begin
      if (res_taken) begin
        if (pht[res_idx] != '1) pht[res_idx] <= pht[res_idx] + CNT_W'(1);
      end else begin
        if (pht[res_idx] != '0) pht[res_idx] <= pht[res_idx] - CNT_W'(1);
      end
      ghr <= {ghr[IDX_W-2:0], res_taken};
      if (br_count != bp_pkg::STAT_MAX) br_count <= br_count + 16'(1);
      if (mispredict && (mp_count != bp_pkg::STAT_MAX)) mp_count <= mp_count + 16'(1);
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Randomized and directed bench for gshare_branch_predictor against an array-based reference model.
module tb_gshare_branch_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pc_F;
  logic       prediction;
  logic       hit;
  logic [4:0] pred_target;
  logic [3:0] GHR_value;
  logic       res_valid;
  logic [4:0] res_pc;
  logic [3:0] res_idx;
  logic       res_taken;
  logic       res_pred;
  logic       res_hit;
  logic [4:0] res_target;
  logic       flush_hit;
  logic [4:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  gshare_branch_predictor dut (
    .clk         (clk),
    .reset       (reset),
    .pc_F        (pc_F),
    .prediction  (prediction),
    .hit         (hit),
    .pred_target (pred_target),
    .GHR_value   (GHR_value),
    .res_valid   (res_valid),
    .res_pc      (res_pc),
    .res_idx     (res_idx),
    .res_taken   (res_taken),
    .res_pred    (res_pred),
    .res_hit     (res_hit),
    .res_target  (res_target),
    .flush_hit   (flush_hit),
    .redirect_pc (redirect_pc),
    .br_count    (br_count),
    .mp_count    (mp_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  int pht_m   [16];
  int ghr_m;
  bit btb_v   [16];
  int btb_tag [16];
  int btb_tgt [16];
  int br_m, mp_m;
  bit known;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      pht_m[i]   = 1;
      btb_v[i]   = 0;
      btb_tag[i] = 0;
      btb_tgt[i] = 0;
    end
    ghr_m = 0;
    br_m  = 0;
    mp_m  = 0;
  endtask

  // One clock: drive at negedge, check combinational view, update model at posedge.
  task automatic step(input bit rst, input int pc, input bit rv, input int rpc, input int ridx,
                      input bit rt, input bit rp, input bit rh, input int rtgt);
    bit mis;
    bit exp_hit;
    int exp_redir;
    int fidx;
    reset      = rst;
    pc_F       = 5'(pc);
    res_valid  = rv;
    res_pc     = 5'(rpc);
    res_idx    = 4'(ridx);
    res_taken  = rt;
    res_pred   = rp;
    res_hit    = rh;
    res_target = 5'(rtgt);
    #1;
    mis       = rv && ((rh && rp) != rt);
    exp_redir = !mis ? 0 : (rt ? rtgt : (rpc + 1) % 32);
    check("flush_hit", 32'(flush_hit), 32'(mis));
    check("redirect_pc", 32'(redirect_pc), exp_redir);
    if (known) begin
      fidx    = (pc % 16) ^ ghr_m;
      exp_hit = btb_v[pc % 16] && (btb_tag[pc % 16] == pc / 16);
      check("prediction", 32'(prediction), 32'(pht_m[fidx] >= 2));
      check("hit", 32'(hit), 32'(exp_hit));
      if (exp_hit) check("pred_target", 32'(pred_target), btb_tgt[pc % 16]);
      check("GHR_value", 32'(GHR_value), ghr_m);
      check("br_count", 32'(br_count), br_m);
      check("mp_count", 32'(mp_count), mp_m);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
      known = 1;
    end else if (rv) begin
      pht_m[ridx] = rt ? ((pht_m[ridx] == 3) ? 3 : pht_m[ridx] + 1)
                       : ((pht_m[ridx] == 0) ? 0 : pht_m[ridx] - 1);
      ghr_m = (ghr_m * 2 + int'(rt)) % 16;
      if (rt) begin
        btb_v[rpc % 16]   = 1;
        btb_tag[rpc % 16] = rpc / 16;
        btb_tgt[rpc % 16] = rtgt;
      end
      if (br_m < 65535) br_m++;
      if (mis && mp_m < 65535) mp_m++;
    end
    @(negedge clk);
  endtask

  task automatic rand_step(input bit allow_rst);
    step(allow_rst && ($urandom_range(0, 199) == 0),
         int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
         int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         int'($urandom_range(0, 31)));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    known = 0;
    model_reset();
    @(negedge clk);

    // Reset, then observe reset state at pc_F=5
    step(1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0, 0, 0);
    check("pred_target_rst", 32'(pred_target), 0);

    // Cold taken branch, then visibility next cycle
    step(0, 5, 1, 5, 5, 1, 0, 0, 12);
    step(0, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5 ^ ghr_m, 0, 0, 0, 0, 0, 0, 0);

    // Counter saturation at index 3, then a predicted-taken not-taken
    for (int i = 0; i < 4; i++) step(0, 3, 1, 3, 3, 1, 0, 0, 8);
    step(0, 3 ^ ghr_m, 0, 0, 0, 0, 0, 0, 0);
    step(0, 3, 1, 3, 3, 0, 1, 1, 8);
    step(0, 3 ^ ghr_m, 0, 0, 0, 0, 0, 0, 0);

    // PC wrap-around on fall-through and BTB tag mismatch
    step(0, 0, 1, 31, 6, 0, 1, 1, 3);
    step(0, 0, 1, 15, 15, 1, 0, 0, 9);
    step(0, 31, 0, 0, 0, 0, 0, 0, 0);
    step(0, 15, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle BTB write and read, then visibility
    step(0, 7, 1, 7, 7, 1, 0, 0, 20);
    step(0, 7, 0, 0, 0, 0, 0, 0, 0);

    // Resolution coinciding with reset must not update
    step(1, 7, 1, 2, 2, 1, 0, 0, 5);
    step(0, 7, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional reset
    for (int i = 0; i < 2000; i++) rand_step(1'b1);

    // Drive branch count to saturation and beyond
    while (br_m < 65535) rand_step(1'b0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 4, 4, 1, 0, 0, 9);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("br_count_sat", 32'(br_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
